// File: rtl/gain_entry_sequencer.sv
// Sequences Ctrl + three digit keys + Enter into an atomic commit of Gain1..Gain3.
// Optional inactivity timeout while an entry is open: define GAIN_TIMEOUT_EN.
module gain_entry_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned CNT_W          = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic       key_ctrl,
    input  logic       key_enter,
    input  logic       key_digit,
    input  logic [1:0] key_value,
    output logic [1:0] Gain1,
    output logic [1:0] Gain2,
    output logic [1:0] Gain3,
    output logic       DatosListos,
    output logic       entry_active,
    output logic [1:0] entry_index,
    output logic       err
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitG1,
        StWaitG2,
        StWaitG3,
        StWaitEnter
    } state_e;

    if (!((CNT_W >= 32) || ((64'd1 << CNT_W) > 64'(TIMEOUT_CYCLES)))) begin : g_cnt_w_too_small
        $error("CNT_W too narrow to hold TIMEOUT_CYCLES");
    end

    state_e     state_q, state_d;
    logic [1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [1:0] gain1_q, gain1_d, gain2_q, gain2_d, gain3_q, gain3_d;
    logic       dl_q, dl_d;
    logic       err_q, err_d;

    // Priority decode: ctrl > enter > digit; a flagless strobe is no event at all.
    logic ev_ctrl, ev_enter, ev_digit, ev_any;
    assign ev_ctrl  = key_valid & key_ctrl;
    assign ev_enter = key_valid & ~key_ctrl & key_enter;
    assign ev_digit = key_valid & ~key_ctrl & ~key_enter & key_digit;
    assign ev_any   = ev_ctrl | ev_enter | ev_digit;

`ifdef GAIN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        gain1_d = gain1_q;
        gain2_d = gain2_q;
        gain3_d = gain3_q;
        dl_d    = 1'b0;
        err_d   = 1'b0;

        if (ev_ctrl) begin
            state_d = StWaitG1;
            s1_d    = 2'b00;
            s2_d    = 2'b00;
            s3_d    = 2'b00;
        end else begin
            unique case (state_q)
                StIdle: ;
                StWaitG1: begin
                    if (ev_digit) begin
                        s1_d    = key_value;
                        state_d = StWaitG2;
                    end else if (ev_enter) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
                StWaitG2: begin
                    if (ev_digit) begin
                        s2_d    = key_value;
                        state_d = StWaitG3;
                    end else if (ev_enter) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
                StWaitG3: begin
                    if (ev_digit) begin
                        s3_d    = key_value;
                        state_d = StWaitEnter;
                    end else if (ev_enter) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
                StWaitEnter: begin
                    if (ev_enter) begin
                        gain1_d = s1_q;
                        gain2_d = s2_q;
                        gain3_d = s3_q;
                        dl_d    = 1'b1;
                        state_d = StIdle;
                    end else if (ev_digit) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

`ifdef GAIN_TIMEOUT_EN
        // Only idle cycles of an open entry advance the counter; any event restarts it.
        cnt_d = '0;
        if (state_q != StIdle && !ev_any) begin
            if (cnt_q == CntLast) begin
                state_d = StIdle;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            s1_q    <= 2'b00;
            s2_q    <= 2'b00;
            s3_q    <= 2'b00;
            gain1_q <= 2'b00;
            gain2_q <= 2'b00;
            gain3_q <= 2'b00;
            dl_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            gain1_q <= gain1_d;
            gain2_q <= gain2_d;
            gain3_q <= gain3_d;
            dl_q    <= dl_d;
            err_q   <= err_d;
        end
    end

`ifdef GAIN_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        entry_index = 2'd0;
        unique case (state_q)
            StIdle:      entry_index = 2'd0;
            StWaitG1:    entry_index = 2'd1;
            StWaitG2:    entry_index = 2'd2;
            StWaitG3:    entry_index = 2'd3;
            StWaitEnter: entry_index = 2'd3;
            default:     entry_index = 2'd0;
        endcase
    end

    assign entry_active = (state_q != StIdle);
    assign Gain1        = gain1_q;
    assign Gain2        = gain2_q;
    assign Gain3        = gain3_q;
    assign DatosListos  = dl_q;
    assign err          = err_q;

endmodule

// File: tb/tb_gain_entry_sequencer.sv
// Bench for gain_entry_sequencer: fixed vector table, directed corner cases and
// randomized events checked against an entry-level reference model.
module tb_gain_entry_sequencer;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0, key_ctrl = 1'b0, key_enter = 1'b0, key_digit = 1'b0;
    logic [1:0] key_value = 2'd0;
    logic [1:0] Gain1, Gain2, Gain3, entry_index;
    logic       DatosListos, entry_active, err;

    gain_entry_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_ctrl    (key_ctrl),
        .key_enter   (key_enter),
        .key_digit   (key_digit),
        .key_value   (key_value),
        .Gain1       (Gain1),
        .Gain2       (Gain2),
        .Gain3       (Gain3),
        .DatosListos (DatosListos),
        .entry_active(entry_active),
        .entry_index (entry_index),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an open entry is a list of collected digits.
    bit       m_open;
    int       m_n;
    bit [1:0] m_s[3];
    bit [1:0] m_g[3];
    bit       m_dl, m_err;
    int       m_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_index();
        if (!m_open) return 2'd0;
        return (m_n >= 2) ? 2'd3 : 2'(m_n + 1);
    endfunction

    task automatic model_reset();
        m_open = 0; m_n = 0; m_dl = 0; m_err = 0; m_idle = 0;
        for (int i = 0; i < 3; i++) begin
            m_s[i] = 0;
            m_g[i] = 0;
        end
    endtask

    task automatic model_step(input logic v, input logic c, input logic e, input logic d,
                              input logic [1:0] val);
        m_dl  = 0;
        m_err = 0;
        if (v && c) begin
            m_open = 1; m_n = 0; m_idle = 0;
            for (int i = 0; i < 3; i++) m_s[i] = 0;
        end else if (v && e) begin
            m_idle = 0;
            if (m_open) begin
                if (m_n == 3) begin
                    for (int i = 0; i < 3; i++) m_g[i] = m_s[i];
                    m_dl = 1;
                end else begin
                    m_err = 1;
                end
                m_open = 0;
            end
        end else if (v && d) begin
            m_idle = 0;
            if (m_open) begin
                if (m_n < 3) begin
                    m_s[m_n] = val;
                    m_n++;
                end else begin
                    m_err  = 1;
                    m_open = 0;
                end
            end
        end else begin
`ifdef GAIN_TIMEOUT_EN
            if (m_open) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_err  = 1;
                    m_open = 0;
                    m_idle = 0;
                end
            end
`endif
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".gain1"}, 32'(Gain1), 32'(m_g[0]));
        chk({tag, ".gain2"}, 32'(Gain2), 32'(m_g[1]));
        chk({tag, ".gain3"}, 32'(Gain3), 32'(m_g[2]));
        chk({tag, ".dl"}, 32'(DatosListos), 32'(m_dl));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
        chk({tag, ".active"}, 32'(entry_active), 32'(m_open));
        chk({tag, ".index"}, 32'(entry_index), 32'(m_index()));
    endtask

    // Drive one cycle of input, let the edge happen, then check #1 later.
    task automatic apply(input logic v, input logic c, input logic e, input logic d,
                         input logic [1:0] val, input string tag);
        key_valid = v; key_ctrl = c; key_enter = e; key_digit = d; key_value = val;
        @(posedge clk);
        model_step(v, c, e, d, val);
        #1;
        check_model(tag);
    endtask

    task automatic idle_cycle(input string tag);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, tag);
    endtask

    typedef struct {
        logic       v, c, e, d;
        logic [1:0] val;
        logic [1:0] g1, g2, g3;
        logic       dl, er, act;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic c, input logic e, input logic d,
                       input logic [1:0] val, input logic [1:0] g1, input logic [1:0] g2,
                       input logic [1:0] g3, input logic dl, input logic er, input logic act,
                       input logic [1:0] idx);
        vec_t t;
        t.v = v; t.c = c; t.e = e; t.d = d; t.val = val;
        t.g1 = g1; t.g2 = g2; t.g3 = g3; t.dl = dl; t.er = er; t.act = act; t.idx = idx;
        tbl.push_back(t);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_model(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit saw_err;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model("reset");
        rst = 1'b0;

        //   v  c  e  d  val g1 g2 g3 dl er act idx
        // nominal entry 2/1/3
        add(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 1, 2,  0, 0, 0, 0, 0, 1, 2);
        add(1, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1, 3);
        add(1, 0, 0, 1, 3,  0, 0, 0, 0, 0, 1, 3);
        add(1, 0, 1, 0, 0,  2, 1, 3, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,  2, 1, 3, 0, 0, 0, 0);
        // premature enter
        add(1, 1, 0, 0, 0,  2, 1, 3, 0, 0, 1, 1);
        add(1, 0, 0, 1, 1,  2, 1, 3, 0, 0, 1, 2);
        add(1, 0, 1, 0, 0,  2, 1, 3, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,  2, 1, 3, 0, 0, 0, 0);
        // ctrl restart -> 1/0/2
        add(1, 1, 0, 0, 0,  2, 1, 3, 0, 0, 1, 1);
        add(1, 0, 0, 1, 3,  2, 1, 3, 0, 0, 1, 2);
        add(1, 0, 0, 1, 3,  2, 1, 3, 0, 0, 1, 3);
        add(1, 1, 0, 0, 0,  2, 1, 3, 0, 0, 1, 1);
        add(1, 0, 0, 1, 1,  2, 1, 3, 0, 0, 1, 2);
        add(1, 0, 0, 1, 0,  2, 1, 3, 0, 0, 1, 3);
        add(1, 0, 0, 1, 2,  2, 1, 3, 0, 0, 1, 3);
        add(1, 0, 1, 0, 0,  1, 0, 2, 1, 0, 0, 0);
        // ctrl+enter in WAIT_ENTER acts as ctrl, then commit 3/3/3 and restart right after
        add(1, 1, 0, 0, 0,  1, 0, 2, 0, 0, 1, 1);
        add(1, 0, 0, 1, 3,  1, 0, 2, 0, 0, 1, 2);
        add(1, 0, 0, 1, 3,  1, 0, 2, 0, 0, 1, 3);
        add(1, 0, 0, 1, 3,  1, 0, 2, 0, 0, 1, 3);
        add(1, 1, 1, 0, 0,  1, 0, 2, 0, 0, 1, 1);
        add(1, 0, 0, 1, 3,  1, 0, 2, 0, 0, 1, 2);
        add(1, 0, 0, 1, 3,  1, 0, 2, 0, 0, 1, 3);
        add(1, 0, 0, 1, 3,  1, 0, 2, 0, 0, 1, 3);
        add(1, 0, 1, 0, 0,  3, 3, 3, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0,  3, 3, 3, 0, 0, 1, 1);
        add(1, 0, 0, 1, 1,  3, 3, 3, 0, 0, 1, 2);

        foreach (tbl[i]) begin
            key_valid = tbl[i].v; key_ctrl = tbl[i].c; key_enter = tbl[i].e;
            key_digit = tbl[i].d; key_value = tbl[i].val;
            @(posedge clk);
            model_step(tbl[i].v, tbl[i].c, tbl[i].e, tbl[i].d, tbl[i].val);
            #1;
            chk($sformatf("tbl%0d.gains", i), 32'({Gain1, Gain2, Gain3}),
                32'({tbl[i].g1, tbl[i].g2, tbl[i].g3}));
            chk($sformatf("tbl%0d.dl", i), 32'(DatosListos), 32'(tbl[i].dl));
            chk($sformatf("tbl%0d.err", i), 32'(err), 32'(tbl[i].er));
            chk($sformatf("tbl%0d.active", i), 32'(entry_active), 32'(tbl[i].act));
            chk($sformatf("tbl%0d.index", i), 32'(entry_index), 32'(tbl[i].idx));
        end

        // Reset mid-entry after a 3/3/3 commit clears everything asynchronously.
        key_valid = 1'b0;
        do_reset("midreset");
        chk("midreset.gains", 32'({Gain1, Gain2, Gain3}), 32'h0);

        // First edge after release accepts an event; idle-state enter/digit ignored.
        apply(1, 0, 1, 0, 0, "idle_enter");
        apply(1, 0, 0, 1, 2, "idle_digit");
        apply(1, 1, 0, 0, 0, "rel_ctrl");
        chk("rel_ctrl.index", 32'(entry_index), 32'd1);
        apply(1, 0, 0, 0, 1, "noflag");
        chk("noflag.index", 32'(entry_index), 32'd1);
        apply(1, 0, 0, 1, 0, "d0");
        apply(1, 0, 0, 1, 1, "d1");
        apply(1, 0, 0, 1, 2, "d2");
        apply(1, 0, 0, 1, 1, "extra_digit");
        chk("extra_digit.err", 32'(err), 32'd1);
        chk("extra_digit.gains", 32'({Gain1, Gain2, Gain3}), 32'h0);
        idle_cycle("after_err");
        chk("after_err.err", 32'(err), 32'd0);

        // Timeout / no-timeout: Ctrl, digit 2, then long idle.
        apply(1, 1, 0, 0, 0, "to_ctrl");
        apply(1, 0, 0, 1, 2, "to_d2");
`ifdef GAIN_TIMEOUT_EN
        for (int i = 1; i < int'(TO); i++) idle_cycle("to_wait");
        chk("to_wait.err", 32'(err), 32'd0);
        idle_cycle("to_fire");
        chk("to_fire.err", 32'(err), 32'd1);
        chk("to_fire.active", 32'(entry_active), 32'd0);
        chk("to_fire.gains", 32'({Gain1, Gain2, Gain3}), 32'h0);
        saw_err = 0;
        for (int i = 0; i < 100; i++) begin
            idle_cycle("idle100");
            if (err) saw_err = 1;
        end
        chk("idle100.no_err", 32'(saw_err), 32'd0);
        apply(1, 1, 0, 0, 0, "post_ctrl");
        apply(1, 0, 0, 1, 2, "post_d2");
`else
        saw_err = 0;
        for (int i = 0; i < 1000; i++) begin
            idle_cycle("hold1000");
            if (err) saw_err = 1;
        end
        chk("hold1000.no_err", 32'(saw_err), 32'd0);
        chk("hold1000.index", 32'(entry_index), 32'd2);
`endif
        apply(1, 0, 0, 1, 1, "late_d1");
        apply(1, 0, 0, 1, 0, "late_d0");
        apply(1, 0, 1, 0, 0, "late_enter");
        chk("late_enter.gains", 32'({Gain1, Gain2, Gain3}), 32'({2'd2, 2'd1, 2'd0}));
        chk("late_enter.dl", 32'(DatosListos), 32'd1);

        // Randomized events, with occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            logic [1:0] val;
            r   = $urandom_range(0, 99);
            val = 2'($urandom_range(0, 3));
            if (r == 0) do_reset("rnd_reset");
            else if (r < 10) apply(1, 1, 1'($urandom), 1'($urandom), val, "rnd");
            else if (r < 18) apply(1, 0, 1, 1'($urandom), val, "rnd");
            else if (r < 65) apply(1, 0, 0, 1, val, "rnd");
            else if (r < 70) apply(1, 0, 0, 0, val, "rnd");
            else if (r < 75) apply(0, 1'($urandom), 1'($urandom), 1'($urandom), val, "rnd");
            else idle_cycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gain_entry_sequencer.md
# gain_entry_sequencer

Sequences keyboard entry of the three 2-bit equalizer gains from decoded PS/2 key events. Sits between the key identifier/decoder stage and the gain consumers. Accepts a Ctrl-initiated sequence of three digit keys and an Enter key. Commits all three gains atomically with a one-cycle `DatosListos` strobe, and rejects malformed or stale sequences without disturbing the committed gains.

## Interface
- `TIMEOUT_CYCLES`, 50_000_000 — inactivity limit while an entry is open (1 s at 50 MHz); used only with `GAIN_TIMEOUT_EN`.
- `CNT_W`, 26 — timeout counter width; must satisfy 2^CNT_W > `TIMEOUT_CYCLES`.
- `clk` in 1 — system clock, single clock domain.
- `rst` in 1 — asynchronous, active-high reset.
- `key_valid` in 1 — one-cycle strobe marking a decoded key event.
- `key_ctrl` in 1 — event is Ctrl; qualified by `key_valid`.
- `key_enter` in 1 — event is Enter; qualified by `key_valid`.
- `key_digit` in 1 — event is a gain digit; qualified by `key_valid`.
- `key_value` in 2 — digit value 0–3; meaningful only with `key_digit`.
- `Gain1`, `Gain2`, `Gain3` out 2 each — committed gains.
- `DatosListos` out 1 — one-cycle commit strobe.
- `entry_active` out 1 — high whenever the FSM is not in IDLE.
- `entry_index` out 2 — next gain expected: 0 in IDLE, 1–3 in WAIT_G1..G3, 3 in WAIT_ENTER.
- `err` out 1 — one-cycle strobe on an aborted entry.

## Operation
- **Event decode.** An event exists only when `key_valid`=1. Flag priority is ctrl > enter > digit. Any other `key_valid` event, or no flag set, is ignored.
- **Shadow registers.** `s1`, `s2`, `s3`, 2 bits each. They are cleared to 0 on every Ctrl event.
- **FSM states:** IDLE, WAIT_G1, WAIT_G2, WAIT_G3, WAIT_ENTER.
- **IDLE**
  - ctrl → WAIT_G1.
  - enter and digit are ignored; no `err`.
- **WAIT_Gn (n = 1..3)**
  - digit → `sn` ← `key_value`; go to WAIT_G(n+1), or to WAIT_ENTER when n = 3.
  - ctrl → restart at WAIT_G1 with shadows cleared.
  - enter → `err`; go to IDLE.
- **WAIT_ENTER**
  - enter → `Gain1..3` ← `s1..s3`, `DatosListos` ← 1; go to IDLE.
  - ctrl → restart at WAIT_G1.
  - digit → `err`; go to IDLE.
- **Abort rule.** An aborted entry never modifies `Gain1..3`.
- **Output registers.** `DatosListos` and `err` are registered and auto-clear after one cycle.
- **Reset.** Asserting `rst` at any point, including mid-entry, forces:
  - state IDLE;
  - `s1..s3` = 0;
  - `Gain1..3` = 2'b00;
  - `DatosListos` = 0, `err` = 0, `entry_active` = 0, `entry_index` = 0;
  - timeout counter = 0.

## Timing
- All state changes occur on the rising `clk` edge that samples `key_valid`=1.
- **Commit.** For an Enter sampled at edge N, the new `Gain1..3` and `DatosListos`=1 are visible from edge N to edge N+1. `DatosListos` is 0 after edge N+1.
- **Error strobe.** `err` is high for exactly one cycle after the aborting edge.
- **Back-to-back events.** Events on consecutive cycles are each processed; no dead cycles are required.
- **Same-edge commit and restart.** Ctrl sampled on the edge after a commit starts a new entry normally; `DatosListos` still pulses.
- **Reset release.** The first edge after `rst` deasserts may accept an event.

## Configuration
- **Macro:** `GAIN_TIMEOUT_EN`.
- **Defined:**
  - A `CNT_W`-bit counter runs while the state is not IDLE.
  - The counter clears on every processed event and on entry to IDLE.
  - When the counter reaches `TIMEOUT_CYCLES`-1 with no event that cycle, the next edge goes to IDLE and pulses `err`; shadows are discarded and gains are unchanged.
  - An event on the terminal-count cycle takes precedence and clears the counter.
- **Undefined:** no counter exists; the FSM waits indefinitely in any WAIT state.

## Test plan
- **Nominal entry.** Reset, then Ctrl, digit 2, digit 1, digit 3, Enter on separate cycles → `Gain1/2/3` = 2/1/3 and `DatosListos` high for exactly 1 cycle after the Enter edge; `entry_active` = 0.
- **Premature Enter.** Ctrl, digit 1, Enter → `err` pulse, gains remain 0/0/0, state IDLE, `DatosListos` never asserted.
- **Ctrl restart.** Ctrl, digit 3, digit 3, Ctrl, digit 1, digit 0, digit 2, Enter → gains 1/0/2; `entry_index` returns to 1 after the second Ctrl.
- **Priority and reset.** A `key_valid` with `key_ctrl`=`key_enter`=1 while in WAIT_ENTER → treated as Ctrl, no commit. Then assert `rst` mid-entry after a committed 3/3/3 → gains 0/0/0 and all strobes 0.
- **Timeout (with `GAIN_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16).** Ctrl, digit 2, then idle → `err` exactly 16 cycles after the digit edge, state IDLE, prior gains kept. Idle in IDLE for 100 cycles → no `err`.
- **No timeout (without macro).** Same stimulus as the timeout case, held for 1000 cycles → no `err`, still in WAIT_G2. Then digit 1, digit 0, Enter → gains 2/1/0.
